// File: rtl/sync_modn_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_modn_counter_if
// Description : Control and status bundle for sync_modn_counter. The
//               master (the controlling logic) drives clr/load/load_val/en/up.
//               The slave (the counter) drives q/tc/wrap/load_err.
//               Digit i of load_val and q sits at bits [i*W +: W], with
//               digit 0 least significant.
// Ports       : clr, load, load_val[DIGITS*W], en, up   (master -> slave)
//               q[DIGITS*W], tc, wrap, load_err          (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_modn_counter_if #(
    parameter int MODULUS = 10,
    parameter int DIGITS  = 2
);
    // Bits per digit. This is the same derivation that the counter uses.
    localparam int W = (MODULUS > 2) ? $clog2(MODULUS) : 1;

    logic                  clr;
    logic                  load;
    logic [DIGITS*W-1:0]   load_val;
    logic                  en;
    logic                  up;
    logic [DIGITS*W-1:0]   q;
    logic                  tc;
    logic                  wrap;
    logic                  load_err;

    modport master (
        output clr, load, load_val, en, up,
        input  q, tc, wrap, load_err
    );

    modport slave (
        input  clr, load, load_val, en, up,
        output q, tc, wrap, load_err
    );
endinterface
`default_nettype wire

// File: rtl/sync_modn_counter.sv
`default_nettype none
// ============================================================================
// Module      : sync_modn_counter
// Description : Cascaded modulo-MODULUS counter made of DIGITS digits. It
//               supports count enable, up/down direction, parallel load with
//               per-digit saturation, and synchronous clear. It provides a
//               combinational terminal count and registered wrap and
//               load-error pulses. Per-edge priority is clr > load > en.
// Ports       : clk      - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               bus      - sync_modn_counter_if.slave
//                          (clr, load, load_val, en, up -> q, tc, wrap,
//                           load_err)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_modn_counter #(
    parameter int MODULUS = 10,
    parameter int DIGITS  = 2
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    sync_modn_counter_if.slave    bus
);
    localparam int W = (MODULUS > 2) ? $clog2(MODULUS) : 1;

    localparam logic [W-1:0] c_MAX = W'(MODULUS - 1);
    // This constant is one bit wider so that MODULUS = 2^W stays representable.
    // In that case the out-of-range compare can never be true.
    localparam logic [W:0]   c_MOD = (W+1)'(MODULUS);

    logic [DIGITS*W-1:0] r_q;
    logic                r_wrap;
    logic                r_load_err;

    logic [DIGITS-1:0]   w_term;      // digit at terminal value for direction
    logic [DIGITS:0]     w_carry;     // w_carry[i]: all digits below i terminal
    logic [DIGITS-1:0]   w_over;      // load field out of range
    logic [DIGITS*W-1:0] w_count_q;
    logic [DIGITS*W-1:0] w_load_q;
    logic                w_all_term;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [W-1:0] w_d;
        logic [W-1:0] w_fld;
        logic [W-1:0] w_step;

        assign w_d   = r_q[gi*W +: W];
        assign w_fld = bus.load_val[gi*W +: W];

        assign w_term[gi] = bus.up ? (w_d == c_MAX) : (w_d == '0);

        // A terminal digit wraps to the opposite end of its range.
        // Any other digit moves by one.
        always_comb begin
            w_step = w_d;
            if (bus.up) begin
                w_step = w_term[gi] ? '0 : (w_d + 1'b1);
            end else begin
                w_step = w_term[gi] ? c_MAX : (w_d - 1'b1);
            end
        end

        assign w_count_q[gi*W +: W] = w_carry[gi] ? w_step : w_d;

        assign w_over[gi]          = ({1'b0, w_fld} >= c_MOD);
        assign w_load_q[gi*W +: W] = w_over[gi] ? c_MAX : w_fld;
    end

    // Ripple the "everything below is terminal" condition up the digits.
    always_comb begin
        w_carry[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_carry[i+1] = w_carry[i] & w_term[i];
        end
    end

    assign w_all_term = w_carry[DIGITS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q        <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (bus.clr) begin
            r_q        <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (bus.load) begin
            r_q        <= w_load_q;
            r_wrap     <= 1'b0;
            r_load_err <= |w_over;
        end else begin
            r_load_err <= 1'b0;
            // A wrap is a step taken while the whole counter sits at terminal.
            r_wrap     <= bus.en & w_all_term;
            if (bus.en) begin
                r_q <= w_count_q;
            end
        end
    end

    assign bus.q        = r_q;
    assign bus.tc       = bus.en & w_all_term;
    assign bus.wrap     = r_wrap;
    assign bus.load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_sync_modn_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_modn_counter
// Description : Self-checking bench for sync_modn_counter. It drives a
//               decimal 2-digit instance (A) and a radix-6 3-digit
//               instance (B). Each instance has a reference model that holds
//               the count as a plain integer in the range 0..MODULUS^DIGITS-1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_modn_counter;
    localparam int MA = 10, DA = 2, WA = 4, NA = 100;
    localparam int MB = 6,  DB = 3, WB = 3, NB = 216;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    sync_modn_counter_if #(.MODULUS(MA), .DIGITS(DA)) ifa ();
    sync_modn_counter_if #(.MODULUS(MB), .DIGITS(DB)) ifb ();

    sync_modn_counter #(.MODULUS(MA), .DIGITS(DA)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    sync_modn_counter #(.MODULUS(MB), .DIGITS(DB)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave));

    int checks   = 0;
    int failures = 0;

    // Model state
    int ea_v, eb_v;
    bit ea_wrap, ea_err, eb_wrap, eb_err;

    function automatic logic [63:0] f_pack(int mod, int digs, int w, int v);
        logic [63:0] r = '0;
        int x = v;
        for (int i = 0; i < digs; i++) begin
            r = r | (64'(x % mod) << (i*w));
            x = x / mod;
        end
        return r;
    endfunction

    function automatic int f_load_int(int mod, int digs, int w, logic [63:0] lv);
        int v = 0, p = 1, d;
        for (int i = 0; i < digs; i++) begin
            d = int'((lv >> (i*w)) & ((64'd1 << w) - 64'd1));
            if (d >= mod) d = mod - 1;
            v = v + d*p;
            p = p * mod;
        end
        return v;
    endfunction

    function automatic bit f_load_bad(int mod, int digs, int w, logic [63:0] lv);
        bit b = 1'b0;
        for (int i = 0; i < digs; i++)
            if (int'((lv >> (i*w)) & ((64'd1 << w) - 64'd1)) >= mod) b = 1'b1;
        return b;
    endfunction

    function automatic bit f_tc(int n, int v, logic en, logic up);
        return en && (up ? (v == n-1) : (v == 0));
    endfunction

    // Advance both models by one edge using the current inputs, then wait
    // until just after that edge.
    task automatic cyc();
        if (ifa.clr) begin
            ea_v = 0; ea_wrap = 0; ea_err = 0;
        end else if (ifa.load) begin
            ea_v = f_load_int(MA, DA, WA, 64'(ifa.load_val));
            ea_err = f_load_bad(MA, DA, WA, 64'(ifa.load_val)); ea_wrap = 0;
        end else begin
            ea_err = 0; ea_wrap = f_tc(NA, ea_v, ifa.en, ifa.up);
            if (ifa.en) ea_v = ifa.up ? (ea_v + 1) % NA : (ea_v + NA - 1) % NA;
        end
        if (ifb.clr) begin
            eb_v = 0; eb_wrap = 0; eb_err = 0;
        end else if (ifb.load) begin
            eb_v = f_load_int(MB, DB, WB, 64'(ifb.load_val));
            eb_err = f_load_bad(MB, DB, WB, 64'(ifb.load_val)); eb_wrap = 0;
        end else begin
            eb_err = 0; eb_wrap = f_tc(NB, eb_v, ifb.en, ifb.up);
            if (ifb.en) eb_v = ifb.up ? (eb_v + 1) % NB : (eb_v + NB - 1) % NB;
        end
        @(posedge clk); #1;
    endtask

    task automatic set_a(logic c, logic l, logic [7:0] lv, logic e, logic u);
        ifa.clr = c; ifa.load = l; ifa.load_val = lv; ifa.en = e; ifa.up = u;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ifa.q !== 8'h00) begin failures++; $display("FAIL reset_q: got %h expected 00", ifa.q); end
        checks++; if (ifa.wrap !== 1'b0 || ifa.load_err !== 1'b0) begin failures++; $display("FAIL reset_pulses: got wrap=%b err=%b expected 0 0", ifa.wrap, ifa.load_err); end
        checks++; if (ifa.tc !== 1'b0) begin failures++; $display("FAIL reset_tc: got %b expected 0", ifa.tc); end
        checks++; if (ifb.q !== 9'h000) begin failures++; $display("FAIL reset_qb: got %h expected 000", ifb.q); end
    endtask

    task automatic test_up_count();
        set_a(0, 0, 8'h00, 1, 1);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;                       // first counting edge
        ea_v = 1;
        for (int i = 2; i <= 99; i++) begin
            cyc();
            checks++; if (ifa.q !== 8'(f_pack(MA, DA, WA, i))) begin failures++; $display("FAIL up_q[%0d]: got %h expected %h", i, ifa.q, 8'(f_pack(MA, DA, WA, i))); end
        end
        checks++; if (ifa.q !== 8'h99 || ifa.tc !== 1'b1) begin failures++; $display("FAIL up_99: got q=%h tc=%b expected 99 1", ifa.q, ifa.tc); end
        cyc();
        checks++; if (ifa.q !== 8'h00 || ifa.wrap !== 1'b1) begin failures++; $display("FAIL up_wrap: got q=%h wrap=%b expected 00 1", ifa.q, ifa.wrap); end
        cyc();
        checks++; if (ifa.q !== 8'h01 || ifa.wrap !== 1'b0) begin failures++; $display("FAIL up_wrap_end: got q=%h wrap=%b expected 01 0", ifa.q, ifa.wrap); end
    endtask

    task automatic test_down_wrap();
        set_a(0, 1, 8'h00, 0, 0); cyc();
        set_a(0, 0, 8'h00, 1, 0); #1;
        checks++; if (ifa.tc !== 1'b1) begin failures++; $display("FAIL down_tc: got %b expected 1", ifa.tc); end
        cyc();
        checks++; if (ifa.q !== 8'h99 || ifa.wrap !== 1'b1) begin failures++; $display("FAIL down_wrap: got q=%h wrap=%b expected 99 1", ifa.q, ifa.wrap); end
        cyc();
        checks++; if (ifa.q !== 8'h98 || ifa.wrap !== 1'b0) begin failures++; $display("FAIL down_98: got q=%h wrap=%b expected 98 0", ifa.q, ifa.wrap); end
        cyc();
        checks++; if (ifa.q !== 8'h97) begin failures++; $display("FAIL down_97: got %h expected 97", ifa.q); end
    endtask

    task automatic test_load();
        set_a(0, 1, 8'h47, 1, 1); cyc();
        checks++; if (ifa.q !== 8'h47 || ifa.load_err !== 1'b0) begin failures++; $display("FAIL load_47: got q=%h err=%b expected 47 0", ifa.q, ifa.load_err); end
        set_a(0, 0, 8'h00, 1, 1); cyc();
        checks++; if (ifa.q !== 8'h48) begin failures++; $display("FAIL load_48: got %h expected 48", ifa.q); end
        set_a(0, 1, 8'hA3, 0, 1); cyc();
        checks++; if (ifa.q !== 8'h93 || ifa.load_err !== 1'b1) begin failures++; $display("FAIL load_sat: got q=%h err=%b expected 93 1", ifa.q, ifa.load_err); end
        set_a(0, 0, 8'h00, 0, 1); cyc();
        checks++; if (ifa.q !== 8'h93 || ifa.load_err !== 1'b0) begin failures++; $display("FAIL load_err_end: got q=%h err=%b expected 93 0", ifa.q, ifa.load_err); end
    endtask

    task automatic test_clr();
        set_a(0, 1, 8'h99, 0, 1); cyc();
        set_a(1, 1, 8'hFA, 1, 1); #1;
        checks++; if (ifa.tc !== 1'b1) begin failures++; $display("FAIL clr_tc: got %b expected 1", ifa.tc); end
        cyc();
        checks++; if (ifa.q !== 8'h00 || ifa.wrap !== 1'b0 || ifa.load_err !== 1'b0) begin failures++; $display("FAIL clr_dom: got q=%h wrap=%b err=%b expected 00 0 0", ifa.q, ifa.wrap, ifa.load_err); end
    endtask

    task automatic test_async_reset();
        set_a(0, 1, 8'h25, 0, 1); cyc();
        set_a(0, 0, 8'h00, 1, 1);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (ifa.q !== 8'h00) begin failures++; $display("FAIL async_reset: got %h expected 00", ifa.q); end
        ea_v = 0; ea_wrap = 0; ea_err = 0; eb_v = 0; eb_wrap = 0; eb_err = 0;
        @(posedge clk); #1;
        checks++; if (ifa.q !== 8'h00) begin failures++; $display("FAIL reset_hold: got %h expected 00", ifa.q); end
        @(negedge clk); reset_n = 1'b1;
        cyc();
        checks++; if (ifa.q !== 8'h01) begin failures++; $display("FAIL reset_first_step: got %h expected 01", ifa.q); end
    endtask

    task automatic test_hold_dir();
        set_a(0, 1, 8'h39, 0, 1); cyc();
        set_a(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if (ifa.q !== 8'h39 || ifa.tc !== 1'b0) begin failures++; $display("FAIL hold[%0d]: got q=%h tc=%b expected 39 0", i, ifa.q, ifa.tc); end
        end
        set_a(0, 0, 8'h00, 1, 0); cyc();
        checks++; if (ifa.q !== 8'h38) begin failures++; $display("FAIL dir_down: got %h expected 38", ifa.q); end
        set_a(0, 0, 8'h00, 1, 1); cyc();
        checks++; if (ifa.q !== 8'h39) begin failures++; $display("FAIL dir_up: got %h expected 39", ifa.q); end
        cyc();
        checks++; if (ifa.q !== 8'h40) begin failures++; $display("FAIL carry_40: got %h expected 40", ifa.q); end
    endtask

    task automatic test_modn();
        set_a(0, 0, 8'h00, 0, 1);
        ifb.clr = 1; ifb.load = 0; ifb.load_val = '0; ifb.en = 0; ifb.up = 1; cyc();
        ifb.clr = 0; ifb.en = 1;
        for (int i = 0; i < 215; i++) cyc();
        checks++; if (ifb.q !== 9'b101_101_101 || ifb.tc !== 1'b1) begin failures++; $display("FAIL modn_555: got q=%h tc=%b expected 16d 1", ifb.q, ifb.tc); end
        cyc();
        checks++; if (ifb.q !== 9'h000 || ifb.wrap !== 1'b1) begin failures++; $display("FAIL modn_wrap: got q=%h wrap=%b expected 000 1", ifb.q, ifb.wrap); end
        ifb.en = 0; ifb.load = 1; ifb.load_val = 9'h007; cyc();
        checks++; if (ifb.q !== 9'h005 || ifb.load_err !== 1'b1) begin failures++; $display("FAIL modn_sat: got q=%h err=%b expected 005 1", ifb.q, ifb.load_err); end
        ifb.load = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_a(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) != 0) ? ifa.up : ~ifa.up);
            ifb.clr = ($urandom_range(0, 29) == 0);
            ifb.load = ($urandom_range(0, 9) == 0);
            ifb.load_val = 9'($urandom_range(0, 511));
            ifb.en = ($urandom_range(0, 4) != 0);
            ifb.up = ($urandom_range(0, 15) != 0) ? ifb.up : ~ifb.up;
            #1;
            checks++; if (ifa.tc !== f_tc(NA, ea_v, ifa.en, ifa.up) || ifb.tc !== f_tc(NB, eb_v, ifb.en, ifb.up)) begin
                failures++; $display("FAIL rand_tc[%0d]: got a=%b b=%b expected a=%b b=%b", i, ifa.tc, ifb.tc, f_tc(NA, ea_v, ifa.en, ifa.up), f_tc(NB, eb_v, ifb.en, ifb.up)); end
            cyc();
            checks++; if (ifa.q !== 8'(f_pack(MA, DA, WA, ea_v)) || ifa.wrap !== ea_wrap || ifa.load_err !== ea_err) begin
                failures++; $display("FAIL rand_a[%0d]: got q=%h wrap=%b err=%b expected %h %b %b", i, ifa.q, ifa.wrap, ifa.load_err, 8'(f_pack(MA, DA, WA, ea_v)), ea_wrap, ea_err); end
            checks++; if (ifb.q !== 9'(f_pack(MB, DB, WB, eb_v)) || ifb.wrap !== eb_wrap || ifb.load_err !== eb_err) begin
                failures++; $display("FAIL rand_b[%0d]: got q=%h wrap=%b err=%b expected %h %b %b", i, ifb.q, ifb.wrap, ifb.load_err, 9'(f_pack(MB, DB, WB, eb_v)), eb_wrap, eb_err); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        set_a(0, 0, 8'h00, 0, 1);
        ifb.clr = 0; ifb.load = 0; ifb.load_val = '0; ifb.en = 0; ifb.up = 1;
        ea_v = 0; ea_wrap = 0; ea_err = 0; eb_v = 0; eb_wrap = 0; eb_err = 0;
        test_reset();
        test_up_count();
        test_down_wrap();
        test_load();
        test_clr();
        test_async_reset();
        test_hold_dir();
        test_modn();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
